// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32 memory stage as a handshaked bus master.
// Byte-strobe stores, extended loads, fault and halt detection.
module mem_access_unit #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           RADDR_WIDTH    = 5,
    parameter int unsigned           TIMEOUT_CYCLES = 16,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = 32'h0000_FFFC
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [31:0]            reg_wdata_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [31:0]            mem_data_i,
    input  logic [3:0]             mem_op_i,
    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [ADDR_WIDTH-1:0]  bus_addr_o,
    output logic [3:0]             bus_be_o,
    output logic [31:0]            bus_wdata_o,
    input  logic                   bus_ack_i,
    input  logic [31:0]            bus_rdata_i,
    output logic                   wb_valid_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [31:0]            reg_wdata_o,
    output logic                   fault_o,
    output logic [ADDR_WIDTH-1:0]  fault_addr_o,
    output logic                   halt_o
);

    localparam logic [3:0] OP_SB  = 4'd1;
    localparam logic [3:0] OP_SH  = 4'd2;
    localparam logic [3:0] OP_SW  = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_LH  = 4'd6;
    localparam logic [3:0] OP_LHU = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8;

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [RADDR_WIDTH-1:0]  rd_q, rd_d;
    logic                    rd_we_q, rd_we_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [RADDR_WIDTH-1:0]  wb_waddr_q, wb_waddr_d;
    logic                    wb_we_q, wb_we_d;
    logic [31:0]             wb_wdata_q, wb_wdata_d;
    logic                    fault_q, fault_d;
    logic [ADDR_WIDTH-1:0]   fault_addr_q, fault_addr_d;
    logic                    halt_q, halt_d;

    logic        in_is_mem;
    logic        in_is_store;
    logic        in_misal;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic        accept;
    logic        op_is_load;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

    assign accept = in_valid_i && in_ready_o;

    // Decode the op offered by execute: lanes, strobes, alignment.
    always_comb begin
        in_is_mem   = 1'b1;
        in_is_store = 1'b0;
        in_misal    = 1'b0;
        in_be       = 4'b1111;
        in_wdata    = mem_data_i;
        unique case (mem_op_i)
            OP_SB: begin
                in_is_store = 1'b1;
                in_be       = 4'b0001 << mem_addr_i[1:0];
                in_wdata    = {4{mem_data_i[7:0]}};
            end
            OP_SH: begin
                in_is_store = 1'b1;
                in_misal    = mem_addr_i[0];
                in_be       = 4'b0011 << mem_addr_i[1:0];
                in_wdata    = {2{mem_data_i[15:0]}};
            end
            OP_SW: begin
                in_is_store = 1'b1;
                in_misal    = (mem_addr_i[1:0] != 2'b00);
            end
            OP_LB, OP_LBU: begin
                in_misal = 1'b0;
            end
            OP_LH, OP_LHU: begin
                in_misal = mem_addr_i[0];
            end
            OP_LW: begin
                in_misal = (mem_addr_i[1:0] != 2'b00);
            end
            default: begin
                in_is_mem = 1'b0;
            end
        endcase
    end

    // Pick and extend the addressed lane of the returned read word.
    always_comb begin
        rd_shift   = bus_rdata_i >> {addr_q[1:0], 3'b000};
        op_is_load = 1'b1;
        load_data  = rd_shift;
        unique case (op_q)
            OP_LB:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            OP_LBU: load_data = {24'h0, rd_shift[7:0]};
            OP_LH:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            OP_LHU: load_data = {16'h0, rd_shift[15:0]};
            OP_LW:  load_data = rd_shift;
            default: begin
                op_is_load = 1'b0;
                load_data  = 32'h0;
            end
        endcase
    end

    // Next-state logic: accept, bus access, response and fault capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        rd_we_d      = rd_we_q;
        wb_valid_d   = 1'b0;
        wb_waddr_d   = wb_waddr_q;
        wb_we_d      = wb_we_q;
        wb_wdata_d   = wb_wdata_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        halt_d       = halt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_waddr_d = reg_waddr_i;
                        wb_we_d    = reg_we_i;
                        wb_wdata_d = reg_wdata_i;
                    end else if (in_misal) begin
                        state_d      = FAULT;
                        fault_d      = 1'b1;
                        fault_addr_d = mem_addr_i;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                        op_d    = mem_op_i;
                        addr_d  = mem_addr_i;
                        we_d    = in_is_store;
                        be_d    = in_be;
                        wdata_d = in_wdata;
                        rd_d    = reg_waddr_i;
                        rd_we_d = reg_we_i;
                    end
                end
            end
            ACCESS: begin
                // An ack on the last allowed cycle still completes.
                if (bus_ack_i) begin
                    state_d    = RESP;
                    wb_valid_d = 1'b1;
                    wb_waddr_d = rd_q;
                    wb_we_d    = op_is_load && rd_we_q;
                    wb_wdata_d = load_data;
                    if (op_q == OP_SW && addr_q == HALT_ADDR) begin
                        halt_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = FAULT;
                    fault_d      = 1'b1;
                    fault_addr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset clearing every output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            rd_we_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_waddr_q   <= '0;
            wb_we_q      <= 1'b0;
            wb_wdata_q   <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            rd_we_q      <= rd_we_d;
            wb_valid_q   <= wb_valid_d;
            wb_waddr_q   <= wb_waddr_d;
            wb_we_q      <= wb_we_d;
            wb_wdata_q   <= wb_wdata_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            halt_q       <= halt_d;
        end
    end

    assign in_ready_o   = (state_q == IDLE) && !halt_q && !fault_q;
    assign bus_req_o    = (state_q == ACCESS);
    assign bus_we_o     = we_q;
    assign bus_addr_o   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus_be_o     = be_q;
    assign bus_wdata_o  = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign reg_waddr_o  = wb_waddr_q;
    assign reg_we_o     = wb_we_q;
    assign reg_wdata_o  = wb_wdata_q;
    assign fault_o      = fault_q;
    assign fault_addr_o = fault_addr_q;
    assign halt_o       = halt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random and directed checks of mem_access_unit
// against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int TO = 16;

    localparam logic [3:0] SB  = 4'd1;
    localparam logic [3:0] SH  = 4'd2;
    localparam logic [3:0] SW  = 4'd3;
    localparam logic [3:0] LB  = 4'd4;
    localparam logic [3:0] LBU = 4'd5;
    localparam logic [3:0] LH  = 4'd6;
    localparam logic [3:0] LHU = 4'd7;
    localparam logic [3:0] LW  = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  reg_waddr;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_op;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic        fault;
    logic [31:0] fault_addr;
    logic        halt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_WIDTH     (32),
        .RADDR_WIDTH    (5),
        .TIMEOUT_CYCLES (TO),
        .HALT_ADDR      (32'h0000_FFFC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .reg_waddr_i  (reg_waddr),
        .reg_we_i     (reg_we),
        .reg_wdata_i  (reg_wdata),
        .mem_addr_i   (mem_addr),
        .mem_data_i   (mem_data),
        .mem_op_i     (mem_op),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_addr_o   (bus_addr),
        .bus_be_o     (bus_be),
        .bus_wdata_o  (bus_wdata),
        .bus_ack_i    (bus_ack),
        .bus_rdata_i  (bus_rdata),
        .wb_valid_o   (wb_valid),
        .reg_waddr_o  (wb_waddr),
        .reg_we_o     (wb_we),
        .reg_wdata_o  (wb_wdata),
        .fault_o      (fault),
        .fault_addr_o (fault_addr),
        .halt_o       (halt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_is_mem(input logic [3:0] op);
        return (op >= SB) && (op <= LW);
    endfunction

    function automatic bit m_is_store(input logic [3:0] op);
        return (op >= SB) && (op <= SW);
    endfunction

    function automatic logic [31:0] m_be(input logic [3:0] op,
                                         input logic [31:0] a);
        int off = int'(a % 4);
        if (op == SB) return 32'(1 << off);
        if (op == SH) return 32'(3 << off);
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op,
                                            input logic [31:0] d);
        if (op == SB) return (d & 32'hFF) * 32'h0101_0101;
        if (op == SH) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] r);
        int          off = int'(a % 4);
        logic [31:0] b   = (r >> (8 * off)) & 32'hFF;
        logic [31:0] h   = (r >> (8 * off)) & 32'hFFFF;
        case (op)
            LB:      return (b >= 128) ? b - 32'd256 : b;
            LBU:     return b;
            LH:      return (h >= 32768) ? h - 32'd65536 : h;
            LHU:     return h;
            default: return r;
        endcase
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        bus_ack  = 1'b0;
        @(posedge clk); #1;
        check("rst_req", 32'(bus_req), 0);
        check("rst_we", 32'(bus_we), 0);
        check("rst_addr", bus_addr, 0);
        check("rst_be", 32'(bus_be), 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_wb", 32'(wb_valid), 0);
        check("rst_wa", 32'(wb_waddr), 0);
        check("rst_wwe", 32'(wb_we), 0);
        check("rst_wdat", wb_wdata, 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_faddr", fault_addr, 0);
        check("rst_halt", 32'(halt), 0);
        rst = 1'b0;
    endtask

    // One op through the unit; dly = idle ACCESS cycles before the ack.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] wa,
                         input logic we, input int dly);
        in_valid  = 1'b1;
        mem_op    = op;
        mem_addr  = a;
        mem_data  = d;
        reg_wdata = alu;
        reg_waddr = wa;
        reg_we    = we;
        check("ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        mem_op    = 4'($urandom_range(0, 9));
        mem_addr  = $urandom;
        mem_data  = $urandom;
        reg_wdata = $urandom;
        reg_waddr = 5'($urandom);
        reg_we    = 1'($urandom);
        if (!m_is_mem(op)) begin
            in_valid = 1'b0;
            check("alu_wb", 32'(wb_valid), 1);
            check("alu_data", wb_wdata, alu);
            check("alu_we", 32'(wb_we), 32'(we));
            check("alu_wa", 32'(wb_waddr), 32'(wa));
            check("alu_req", 32'(bus_req), 0);
        end else begin
            check("busy_ready", 32'(in_ready), 0);
            for (int i = 0; i < dly; i++) begin
                check("req_hold", 32'(bus_req), 1);
                check("no_wb", 32'(wb_valid), 0);
                @(posedge clk); #1;
            end
            check("req", 32'(bus_req), 1);
            check("bus_we", 32'(bus_we), 32'(m_is_store(op)));
            check("bus_addr", bus_addr, a - (a % 4));
            check("bus_be", 32'(bus_be), m_be(op, a));
            if (m_is_store(op))
                check("bus_wdata", bus_wdata, m_wdata(op, d));
            bus_ack   = 1'b1;
            bus_rdata = rdata;
            @(posedge clk); #1;
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            in_valid  = 1'b0;
            check("mem_wb", 32'(wb_valid), 1);
            check("mem_wa", 32'(wb_waddr), 32'(wa));
            check("mem_we", 32'(wb_we), m_is_store(op) ? 0 : 32'(we));
            if (!m_is_store(op))
                check("load", wb_wdata, m_load(op, a, rdata));
            check("mem_req_off", 32'(bus_req), 0);
            check("no_fault", 32'(fault), 0);
        end
        @(posedge clk); #1;
        check("wb_pulse", 32'(wb_valid), 0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        int          n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        reg_waddr = '0;
        reg_we    = 1'b0;
        reg_wdata = '0;
        mem_addr  = '0;
        mem_data  = '0;
        mem_op    = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        do_reset();

        do_op(LB, 32'h103, 0, 0, 32'h80FF_1234, 5'd3, 1'b1, 2);
        do_op(LBU, 32'h103, 0, 0, 32'h80FF_1234, 5'd4, 1'b1, 2);
        do_op(SH, 32'h202, 32'hAAAA_BEEF, 0, 0, 5'd6, 1'b1, 0);

        in_valid  = 1'b1;
        mem_op    = 4'd0;
        reg_we    = 1'b1;
        reg_waddr = 5'd1;
        reg_wdata = 32'd5;
        @(posedge clk); #1;
        check("b2b_wb1", 32'(wb_valid), 1);
        check("b2b_d1", wb_wdata, 5);
        check("b2b_rdy", 32'(in_ready), 1);
        reg_wdata = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_wb2", 32'(wb_valid), 1);
        check("b2b_d2", wb_wdata, 7);
        check("b2b_req", 32'(bus_req), 0);
        @(posedge clk); #1;

        for (int t = 0; t < 80; t++) begin
            op = 4'($urandom_range(0, 9));
            a  = $urandom_range(0, 4095);
            if (op == SH || op == LH || op == LHU) a = a & ~32'd1;
            if (op == SW || op == LW) a = a & ~32'd3;
            do_op(op, a, $urandom, $urandom, $urandom, 5'($urandom),
                  1'($urandom), $urandom_range(0, 6));
        end

        do_op(LW, 32'h40, 0, 0, 32'h1234_5678, 5'd9, 1'b1, TO - 1);

        in_valid = 1'b1;
        mem_op   = LW;
        mem_addr = 32'h80;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && bus_req; i++) begin
            n++;
            @(posedge clk); #1;
        end
        check("to_cycles", 32'(n), TO);
        check("to_fault", 32'(fault), 1);
        check("to_faddr", fault_addr, 32'h80);
        check("to_ready", 32'(in_ready), 0);
        check("to_wb", 32'(wb_valid), 0);
        do_reset();

        in_valid = 1'b1;
        mem_op   = LW;
        mem_addr = 32'h006;
        @(posedge clk); #1;
        mem_op = 4'd0;
        check("mis_req", 32'(bus_req), 0);
        check("mis_fault", 32'(fault), 1);
        check("mis_faddr", fault_addr, 32'h006);
        for (int i = 0; i < 3; i++) begin
            check("mis_ready", 32'(in_ready), 0);
            check("mis_wb", 32'(wb_valid), 0);
            check("mis_req2", 32'(bus_req), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        do_reset();

        do_op(SB, 32'hFFFC, 32'h11, 0, 0, 5'd2, 1'b1, 0);
        check("sb_nohalt", 32'(halt), 0);
        do_op(SW, 32'hFFFC, 32'h1, 0, 0, 5'd2, 1'b1, 1);
        check("halt", 32'(halt), 1);
        check("halt_rdy", 32'(in_ready), 0);
        in_valid = 1'b1;
        mem_op   = 4'd0;
        @(posedge clk); #1;
        check("halt_nowb", 32'(wb_valid), 0);
        in_valid = 1'b0;
        do_reset();

        in_valid = 1'b1;
        mem_op   = LW;
        mem_addr = 32'h10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_req", 32'(bus_req), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_req", 32'(bus_req), 0);
        check("mid_rst_wb", 32'(wb_valid), 0);
        check("mid_rst_addr", bus_addr, 0);
        rst     = 1'b0;
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check("stray_wb", 32'(wb_valid), 0);
        check("stray_fault", 32'(fault), 0);
        @(posedge clk); #1;
        check("stray_wb2", 32'(wb_valid), 0);
        check("stray_req", 32'(bus_req), 0);
        check("post_rdy", 32'(in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Pipelined memory-stage controller for the RV32 core: sits between the execute stage and the data-RAM bus.
- Replaces the purely combinational memory stage with a handshaked, multi-cycle bus master:
  - byte-strobe stores, with no read-modify-write
  - sign/zero-extended loads
  - misalignment and bus-timeout fault detection
  - halt detection
- Registered write-back output to the register file.

Parameters:
- ADDR_WIDTH, 32, byte-address width of mem_addr_i and bus_addr_o.
- RADDR_WIDTH, 5, register-file address width.
- TIMEOUT_CYCLES, 16, maximum cycles bus_req_o is held without bus_ack_i before a fault; minimum 2.
- HALT_ADDR, 32'h0000_FFFC, a SW to this address sets halt_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  execute stage presents an op
- in_ready_o  out  1  unit can accept an op this cycle
- reg_waddr_i  in  RADDR_WIDTH  destination register
- reg_we_i  in  1  register write enable
- reg_wdata_i  in  32  ALU result, used for non-memory ops
- mem_addr_i  in  ADDR_WIDTH  byte address
- mem_data_i  in  32  store data (rs2)
- mem_op_i  in  4  codebase op code: SB, SH, SW, LB, LBU, LH, LHU, LW; any other value is a non-memory op
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  ADDR_WIDTH  word-aligned address, low 2 bits = 0
- bus_be_o  out  4  byte strobes
- bus_wdata_o  out  32  lane-shifted store data
- bus_ack_i  in  1  one-cycle completion pulse
- bus_rdata_i  in  32  read word, valid with bus_ack_i
- wb_valid_o  out  1  write-back outputs valid, one-cycle pulse
- reg_waddr_o  out  RADDR_WIDTH  write-back register
- reg_we_o  out  1  write-back enable
- reg_wdata_o  out  32  write-back data
- fault_o  out  1  sticky fault flag
- fault_addr_o  out  ADDR_WIDTH  address of the first faulting access
- halt_o  out  1  sticky halt flag

Behaviour:
- Reset values: every output is 0, state = IDLE, timeout counter = 0.
- Reset is synchronous and mid-operation abandons any outstanding request:
  - bus_req_o drops on the next edge.
  - A late bus_ack_i arriving in IDLE is ignored.
- Handshake: an op is accepted when in_valid_i && in_ready_o. in_ready_o = (state == IDLE) && !halt_o && !fault_o.
- On accept, all inputs are captured into internal registers; outputs are driven only from registered state.

States:
- IDLE:
  - Non-memory op on accept → stay in IDLE; next cycle wb_valid_o = 1, reg_wdata_o = reg_wdata_i, reg_we_o = reg_we_i (latency 1).
  - Memory op on accept → ACCESS.
  - Misaligned op on accept → FAULT. Misaligned means LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
- ACCESS:
  - bus_req_o = 1 with bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o stable until bus_ack_i.
  - Counter increments each cycle without ack.
  - bus_ack_i → RESP, capturing bus_rdata_i.
  - Counter == TIMEOUT_CYCLES-1 with no ack → FAULT.
  - Minimum load/store latency is 2 cycles from accept to wb_valid_o.
- RESP:
  - wb_valid_o = 1 for one cycle, then IDLE.
  - Loads: reg_we_o = reg_we_i.
  - Stores: reg_we_o = 0.
- FAULT:
  - fault_o = 1 and fault_addr_o = the captured address, both sticky until reset.
  - wb_valid_o and bus_req_o stay 0; remains in FAULT.

Store lanes (off = addr[1:0]):
- SB: be = 4'b0001 << off; wdata = {4{data[7:0]}}.
- SH: be = 4'b0011 << off; wdata = {2{data[15:0]}}.
- SW: be = 4'b1111; wdata = data.
- Loads: be = 4'b1111.

Load extraction:
- LB/LBU select rdata byte [8*off +: 8].
- LH/LHU select rdata halfword [8*off +: 16] with off in {0, 2}.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

Halt:
- Set when a SW to HALT_ADDR receives bus_ack_i; the store itself completes normally.
- halt_o is sticky until reset and blocks further accepts.
- A non-SW store to HALT_ADDR does not halt.

Simultaneous events:
- bus_ack_i on the same cycle the counter reaches its limit → ack wins, go to RESP.
- in_valid_i while not ready → op is held by upstream and not captured.

Test Plan:
- LB at address 0x103, bus_rdata_i = 0x80FF_1234 acked after 3 cycles → bus_addr_o = 0x100, bus_be_o = 0xF; wb_valid_o pulses 4 cycles after accept with reg_wdata_o = 0xFFFF_FF80; LBU at the same address gives 0x0000_0080.
- SH at 0x202, data 0xAAAA_BEEF, immediate ack → bus_be_o = 4'b1100, bus_wdata_o = 0xBEEF_BEEF, reg_we_o = 0 on wb_valid_o.
- LW at 0x006 → no bus_req_o; fault_o = 1, fault_addr_o = 0x006; in_ready_o stays 0 until reset.
- LW with bus_ack_i never asserted (TIMEOUT_CYCLES = 16) → bus_req_o held for exactly 16 cycles, then fault_o = 1; ack on cycle 16 instead → RESP, no fault.
- Back-to-back ALU ops with reg_wdata_i = 5, then 7 → wb_valid_o on consecutive cycles with 5, then 7; bus_req_o stays 0.
- SW to 0xFFFC acked → halt_o = 1 the cycle after ack; in_ready_o = 0. Assert rst_i while another load is in ACCESS → all outputs 0 next cycle, and a subsequent stray ack causes no wb_valid_o.
